// File: rtl/timestamp_pkg.sv
// timestamp_pkg
//   Shared definitions for the timestamp generator slice: the slew state
//   encoding and the default widths used by timestamp_gen and its users.
package timestamp_pkg;

  localparam int TIMESTAMP_WIDTH_DEF = 64;
  localparam int FRAC_WIDTH_DEF      = 32;
  localparam int INC_INT_WIDTH_DEF   = 8;
  localparam int ADJ_WIDTH_DEF       = 32;
  localparam int NUM_CAPTURE_DEF     = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SLEW_UP   = 2'd1,
    SLEW_DOWN = 2'd2
  } slew_state_e;

endpackage

// File: rtl/stamp_capture.sv
// stamp_capture
//   One snapshot channel: latches the current timestamp when requested and
//   pulses capture_valid for one cycle on the following clock.
// Ports:
//   axi_aclk       clock
//   axi_resetn     asynchronous active-low reset
//   capture_req    snapshot strobe
//   stamp          timestamp present this cycle
//   capture_value  latched snapshot
//   capture_valid  one-cycle pulse, one cycle after capture_req
module stamp_capture #(
  parameter int WIDTH = 64
) (
  input  logic             axi_aclk,
  input  logic             axi_resetn,
  input  logic             capture_req,
  input  logic [WIDTH-1:0] stamp,
  output logic [WIDTH-1:0] capture_value,
  output logic             capture_valid
);

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      capture_value <= '0;
      capture_valid <= 1'b0;
    end else begin
      capture_valid <= capture_req;
      if (capture_req) capture_value <= stamp;
    end
  end

endmodule

// File: rtl/timestamp_gen.sv
// timestamp_gen
//   Fixed-point timestamp generator. {cnt, frac} advances by incr on every
//   enabled cycle. Software may load the integer part, or request a signed
//   offset that is slewed in one LSB per cycle so the counter stays monotonic.
//   NUM_CAPTURE independent snapshot channels sample the live counter.
// Ports:
//   axi_aclk, axi_resetn   clock, asynchronous active-low reset
//   enable                 count enable (low holds counter and slew)
//   incr                   unsigned fixed-point step per cycle
//   load_valid/load_value  load the integer counter, clear fraction, abort slew
//   adj_valid/adj_ready    signed offset handshake, adj_value in counter LSBs
//   capture_req            per-channel snapshot strobes
//   capture_value          flattened snapshots, channel 0 in the LSBs
//   capture_valid          per-channel one-cycle snapshot pulses
//   stamp_counter          current integer timestamp (registered)
//   slew_active            an adjustment is being applied
module timestamp_gen
  import timestamp_pkg::*;
#(
  parameter int TIMESTAMP_WIDTH = TIMESTAMP_WIDTH_DEF,
  parameter int FRAC_WIDTH      = FRAC_WIDTH_DEF,
  parameter int INC_INT_WIDTH   = INC_INT_WIDTH_DEF,
  parameter int ADJ_WIDTH       = ADJ_WIDTH_DEF,
  parameter int NUM_CAPTURE     = NUM_CAPTURE_DEF
) (
  input  logic                                   axi_aclk,
  input  logic                                   axi_resetn,
  input  logic                                   enable,
  input  logic [INC_INT_WIDTH+FRAC_WIDTH-1:0]    incr,
  input  logic                                   load_valid,
  input  logic [TIMESTAMP_WIDTH-1:0]             load_value,
  input  logic                                   adj_valid,
  output logic                                   adj_ready,
  input  logic [ADJ_WIDTH-1:0]                   adj_value,
  input  logic [NUM_CAPTURE-1:0]                 capture_req,
  output logic [NUM_CAPTURE*TIMESTAMP_WIDTH-1:0] capture_value,
  output logic [NUM_CAPTURE-1:0]                 capture_valid,
  output logic [TIMESTAMP_WIDTH-1:0]             stamp_counter,
  output logic                                   slew_active
);

  localparam int ACC_W = TIMESTAMP_WIDTH + FRAC_WIDTH;

  // Magnitude of a signed offset; the most negative value maps onto the
  // unsigned pattern 2^(ADJ_WIDTH-1), which fits the remaining counter.
  function automatic logic [ADJ_WIDTH-1:0] adj_magnitude(
    input logic signed [ADJ_WIDTH-1:0] v
  );
    if (v[ADJ_WIDTH-1]) return $unsigned(-v);
    return $unsigned(v);
  endfunction

  logic [TIMESTAMP_WIDTH-1:0] cnt;
  logic [FRAC_WIDTH-1:0]      frac;
  slew_state_e                state;
  logic [ADJ_WIDTH-1:0]       remaining;

  logic signed [ADJ_WIDTH-1:0] adj_s;
  logic [ACC_W-1:0]            acc_sum;
  logic [TIMESTAMP_WIDTH-1:0]  sum_cnt;
  logic                        int_adv_nz;
  logic                        adj_accept;
  logic                        last_step;

  assign adj_s      = adj_value;
  assign acc_sum    = {cnt, frac} + ACC_W'(incr);
  assign sum_cnt    = acc_sum[ACC_W-1:FRAC_WIDTH];
  // The integer part of incr is narrower than the counter, so a changed
  // integer part after the add means an advance of at least one LSB.
  assign int_adv_nz = (sum_cnt != cnt);
  assign adj_ready  = (state == IDLE) && !load_valid;
  assign adj_accept = adj_valid && adj_ready;
  assign last_step  = (remaining == ADJ_WIDTH'(1));

  assign stamp_counter = cnt;
  assign slew_active   = (state != IDLE);

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      cnt       <= '0;
      frac      <= '0;
      state     <= IDLE;
      remaining <= '0;
    end else if (load_valid) begin
      cnt       <= load_value;
      frac      <= '0;
      state     <= IDLE;
      remaining <= '0;
    end else begin
      // Accept only happens in IDLE, so it never collides with the slew
      // updates below; a zero offset is acknowledged and dropped.
      if (adj_accept && (adj_s != '0)) begin
        remaining <= adj_magnitude(adj_s);
        if (adj_s[ADJ_WIDTH-1]) state <= SLEW_DOWN;
        else                    state <= SLEW_UP;
      end
      if (enable) begin
        frac <= acc_sum[FRAC_WIDTH-1:0];
        unique case (state)
          SLEW_UP: begin
            cnt       <= sum_cnt + TIMESTAMP_WIDTH'(1);
            remaining <= remaining - ADJ_WIDTH'(1);
            if (last_step) state <= IDLE;
          end
          SLEW_DOWN: begin
            // Retarding only when the counter advances keeps it monotonic;
            // otherwise the LSB is deferred to a later cycle.
            if (int_adv_nz) begin
              cnt       <= sum_cnt - TIMESTAMP_WIDTH'(1);
              remaining <= remaining - ADJ_WIDTH'(1);
              if (last_step) state <= IDLE;
            end else begin
              cnt <= sum_cnt;
            end
          end
          default: cnt <= sum_cnt;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_CAPTURE; i++) begin : g_cap
    stamp_capture #(
      .WIDTH(TIMESTAMP_WIDTH)
    ) u_cap (
      .axi_aclk      (axi_aclk),
      .axi_resetn    (axi_resetn),
      .capture_req   (capture_req[i]),
      .stamp         (cnt),
      .capture_value (capture_value[i*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH]),
      .capture_valid (capture_valid[i])
    );
  end

endmodule

// File: tb/tb_timestamp_gen.sv
module tb_timestamp_gen;

  logic         axi_aclk = 1'b0;
  logic         axi_resetn;
  logic         enable;
  logic [39:0]  incr;
  logic         load_valid;
  logic [63:0]  load_value;
  logic         adj_valid;
  logic         adj_ready;
  logic [31:0]  adj_value;
  logic [1:0]   capture_req;
  logic [127:0] capture_value;
  logic [1:0]   capture_valid;
  logic [63:0]  stamp_counter;
  logic         slew_active;

  localparam logic [39:0] INC_1P5 = 40'h01_8000_0000;
  localparam logic [39:0] INC_1P0 = 40'h01_0000_0000;
  localparam logic [39:0] INC_0P5 = 40'h00_8000_0000;

  timestamp_gen dut (
    .axi_aclk      (axi_aclk),
    .axi_resetn    (axi_resetn),
    .enable        (enable),
    .incr          (incr),
    .load_valid    (load_valid),
    .load_value    (load_value),
    .adj_valid     (adj_valid),
    .adj_ready     (adj_ready),
    .adj_value     (adj_value),
    .capture_req   (capture_req),
    .capture_value (capture_value),
    .capture_valid (capture_valid),
    .stamp_counter (stamp_counter),
    .slew_active   (slew_active)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct packed {
    logic [63:0] cnt;
    logic        slew;
    logic        rdy;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] cap_q0[$];
  logic [63:0] cap_q1[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic expect_now(input logic [63:0] c, input logic s, input logic r);
    exp_q.push_back({c, s, r});
  endtask

  // Monitor: compares the per-cycle state and every capture pulse
  always @(negedge axi_aclk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stamp_counter", stamp_counter, e.cnt);
      chk("slew_active", {63'd0, slew_active}, {63'd0, e.slew});
      chk("adj_ready", {63'd0, adj_ready}, {63'd0, e.rdy});
    end
    if (capture_valid[0]) begin
      if (cap_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL cap0_unexpected actual=%0h required=no_pulse", capture_value[63:0]);
      end else chk("cap0_value", capture_value[63:0], cap_q0.pop_front());
    end
    if (capture_valid[1]) begin
      if (cap_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL cap1_unexpected actual=%0h required=no_pulse", capture_value[127:64]);
      end else chk("cap1_value", capture_value[127:64], cap_q1.pop_front());
    end
  end

  initial begin
    axi_resetn = 1'b0; enable = 1'b0; incr = '0; load_valid = 1'b0; load_value = '0;
    adj_valid = 1'b0; adj_value = '0; capture_req = '0;
    repeat (2) @(posedge axi_aclk);
    #1;
    chk("rst_stamp", stamp_counter, 64'd0);
    chk("rst_slew", {63'd0, slew_active}, 64'd0);
    chk("rst_ready", {63'd0, adj_ready}, 64'd1);
    chk("rst_capval_lo", capture_value[63:0], 64'd0);
    chk("rst_capval_hi", capture_value[127:64], 64'd0);
    chk("rst_capvalid", {62'd0, capture_valid}, 64'd0);

    // Fractional increment 1.5
    axi_resetn = 1'b1; enable = 1'b1; incr = INC_1P5;
    expect_now(0, 0, 1);
    tick; expect_now(1, 0, 1);
    tick; expect_now(3, 0, 1);
    tick; expect_now(4, 0, 1);
    tick; incr = INC_1P0; adj_valid = 1'b1; adj_value = 32'd5; expect_now(6, 0, 1);

    // Positive slew +5
    tick; adj_valid = 1'b0; expect_now(7, 1, 0);
    tick; expect_now(9, 1, 0);
    tick; expect_now(11, 1, 0);
    tick; expect_now(13, 1, 0);
    tick; expect_now(15, 1, 0);
    tick; expect_now(17, 0, 1);
    tick; adj_valid = 1'b1; adj_value = -32'sd3; expect_now(18, 0, 1);

    // Negative slew -3, second request held off while slewing
    tick; adj_value = 32'd7; expect_now(19, 1, 0);
    tick; expect_now(19, 1, 0);
    tick; adj_valid = 1'b0; expect_now(19, 1, 0);
    tick; expect_now(19, 0, 1);
    tick; incr = INC_0P5; adj_valid = 1'b1; adj_value = -32'sd2; expect_now(20, 0, 1);

    // Negative slew with half-LSB steps: deferral on non-advancing cycles
    tick; adj_valid = 1'b0; expect_now(20, 1, 0);
    tick; expect_now(20, 1, 0);
    tick; expect_now(20, 1, 0);
    tick; expect_now(20, 0, 1);
    tick; expect_now(20, 0, 1);
    tick; incr = INC_1P0; load_valid = 1'b1; load_value = 64'd100; expect_now(21, 0, 0);

    // Load then dual capture; then captures with counting paused
    tick; load_valid = 1'b0; capture_req = 2'b11;
    cap_q0.push_back(64'd100); cap_q1.push_back(64'd100); expect_now(100, 0, 1);
    tick; capture_req = 2'b00; expect_now(101, 0, 1);
    tick; enable = 1'b0; capture_req = 2'b01; cap_q0.push_back(64'd102); expect_now(102, 0, 1);
    tick; capture_req = 2'b10; cap_q1.push_back(64'd102); expect_now(102, 0, 1);
    tick; capture_req = 2'b00; enable = 1'b1; load_valid = 1'b1;
    load_value = 64'hFFFF_FFFF_FFFF_FFFE; expect_now(102, 0, 0);

    // Counter wrap
    tick; load_valid = 1'b0; expect_now(64'hFFFF_FFFF_FFFF_FFFE, 0, 1);
    tick; expect_now(64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
    tick; expect_now(0, 0, 1);
    tick; adj_valid = 1'b1; adj_value = 32'd10; expect_now(1, 0, 1);

    // Load aborts an active slew
    tick; adj_valid = 1'b0; expect_now(2, 1, 0);
    tick; load_valid = 1'b1; load_value = 64'd1000; expect_now(4, 1, 0);
    tick; load_valid = 1'b0; expect_now(1000, 0, 1);
    tick; adj_valid = 1'b1; adj_value = 32'd4; expect_now(1001, 0, 1);
    tick; adj_valid = 1'b0; capture_req = 2'b11; expect_now(1002, 1, 0);

    // Asynchronous reset mid-slew with capture pulses in flight
    tick; capture_req = 2'b00; axi_resetn = 1'b0;
    #1;
    chk("arst_stamp", stamp_counter, 64'd0);
    chk("arst_slew", {63'd0, slew_active}, 64'd0);
    chk("arst_capval_lo", capture_value[63:0], 64'd0);
    chk("arst_capval_hi", capture_value[127:64], 64'd0);
    chk("arst_capvalid", {62'd0, capture_valid}, 64'd0);
    chk("arst_ready", {63'd0, adj_ready}, 64'd1);

    repeat (2) @(negedge axi_aclk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("cap0_drained", 64'(cap_q0.size()), 64'd0);
    chk("cap1_drained", 64'(cap_q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timestamp_gen.md
# timestamp_gen

Parametrised timestamp generator for the nf10_timestamp pcore, successor to the free-running stamp counter. Advances a fixed-point time value by a programmable increment per clock, supports software load and slewed (monotonic) signed offset adjustment, and provides per-channel snapshot capture for ingress/egress stamping. Sits in the shared clock domain and feeds all timestamp consumers in the datapath.

## Interface
- TIMESTAMP_WIDTH, 64: integer width of the timestamp.
- FRAC_WIDTH, 32: fractional accumulator width.
- INC_INT_WIDTH, 8: integer bits of the increment.
- ADJ_WIDTH, 32: width of the signed adjustment.
- NUM_CAPTURE, 2: number of capture channels.
- Clock and reset: one clock, `axi_aclk`; reset `axi_resetn`, asynchronous, active-low.
- axi_aclk  in  1  clock.
- axi_resetn  in  1  async active-low reset.
- enable  in  1  count enable; low holds the counter and pauses slew.
- incr  in  INC_INT_WIDTH+FRAC_WIDTH  unsigned fixed-point step per cycle (quasi-static).
- load_valid  in  1  load strobe.
- load_value  in  TIMESTAMP_WIDTH  value to load.
- adj_valid  in  1  adjustment request.
- adj_ready  out  1  adjustment accepted when valid&ready.
- adj_value  in  ADJ_WIDTH  signed offset, in counter LSBs.
- capture_req  in  NUM_CAPTURE  per-channel snapshot strobe.
- capture_value  out  NUM_CAPTURE*TIMESTAMP_WIDTH  flattened snapshots, channel 0 in LSBs.
- capture_valid  out  NUM_CAPTURE  one-cycle pulse per snapshot.
- stamp_counter  out  TIMESTAMP_WIDTH  current timestamp (registered).
- slew_active  out  1  high while an adjustment is being applied.

## Operation
- State {cnt, frac}. When enabled, {cnt, frac} += incr each cycle, modulo 2^(TIMESTAMP_WIDTH+FRAC_WIDTH); fractional carry propagates into cnt; cnt wraps silently.
- Priority per cycle: load > adjustment accept > slew/increment.
- Load: cnt <= load_value, frac <= 0; any slew is aborted (remaining <= 0, state IDLE). Applies regardless of enable.
- adj_ready = (state==IDLE) & ~load_valid. On accept, remaining <= |adj_value|; state <= SLEW_UP if positive, SLEW_DOWN if negative; adj_value==0 is accepted with no state change.
- SLEW_UP (enabled cycle): cnt gets the normal carry plus 1; remaining decrements.
- SLEW_DOWN (enabled cycle): if this cycle's integer advance is >= 1, cnt gets integer advance minus 1 and remaining decrements; otherwise the -1 is deferred (remaining unchanged). cnt never decreases.
- Return to IDLE in the cycle remaining reaches 0. slew_active = (state != IDLE).
- enable low: cnt, frac, remaining held; loads and captures still operate.
- Capture channel i: on capture_req[i], capture_value[i] <= stamp_counter value present that cycle; capture_valid[i] pulses next cycle. Channels independent; simultaneous requests all serviced.

## Timing
- Reset (asynchronous assert, synchronous deassert expected upstream): stamp_counter 0, frac 0, state IDLE, remaining 0, slew_active 0, capture_value all 0, capture_valid 0; adj_ready 1 when load_valid low.
- Load: load_value on stamp_counter one cycle after load_valid.
- Increment/slew: effect visible on stamp_counter the cycle after the enabled edge.
- Capture latency: 1 cycle; captured value equals stamp_counter in the request cycle.
- Reset mid-slew or mid-capture: all state cleared immediately, no pending pulses.

## Structure
- Package timestamp_pkg: slew state enum (IDLE, SLEW_UP, SLEW_DOWN), default width constants.
- Sub-module stamp_capture: one capture register plus valid pulse, instantiated NUM_CAPTURE times via generate.

## Test plan
- incr=1.5 (0x01_80000000), enable after reset -> stamp_counter 1, 3, 4, 6 on successive cycles.
- incr=1.0, adj_value=+5 -> counter steps by 2 for 5 cycles then by 1; slew_active high exactly 5 cycles; adj_ready low meanwhile.
- incr=1.0, adj_value=-3 -> counter holds 3 cycles then resumes; never decreases; second adj_valid during slew not accepted.
- load 0xFFFF_FFFF_FFFF_FFFE, incr=1.0 -> 0xFFFF_FFFF_FFFF_FFFF, 0, 1; load during slew -> slew_active drops next cycle, adj_ready 1.
- capture_req=2'b11 at stamp_counter=100 -> both capture_value=100, capture_valid=2'b11 one cycle; enable low -> captures still return held value.
- axi_resetn asserted mid-slew -> stamp_counter, capture_value, slew_active 0 immediately without clock.
